mem_access_unit: RTL and testbench

MEM-stage load/store controller. It consumes the EX/MEM pipeline-register outputs: MemWrite, MemRead, address, store data and access size. It runs each access over a request/acknowledge data-memory bus that may take a variable number of cycles, stalling the pipeline until the access completes. Store data is lane-replicated with byte enables, and load data is lane-selected and sign- or zero-extended for the MEM/WB register.

---
 rtl/mem_access_unit.sv | 147 ++++++++++++++
 tb/tb_mem_access_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: aligns stores onto byte lanes, runs a req/ack bus access
// with timeout, and formats load data; stalls upstream while an access is outstanding.
module mem_access_unit #(
  parameter int TimeoutCycles = 255
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        ClockEnable,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  output logic        Stall,
  output logic [31:0] RData,
  output logic        Misalign,
  output logic        BusErr,
  output logic        BusReq,
  output logic        BusWe,
  output logic [31:0] BusAddr,
  output logic [3:0]  BusBe,
  output logic [31:0] BusWData,
  input  logic        BusAck,
  input  logic [31:0] BusRData
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Timeout fires on the last permitted REQ cycle so BusReq is high exactly TimeoutCycles cycles.
  localparam logic [15:0] TMO_LAST = 16'(TimeoutCycles - 1);

  logic [1:0]  state;
  logic [15:0] tmo_cnt;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  lane_q;

  logic        access;
  logic        misaligned;
  logic [3:0]  be_nxt;
  logic [31:0] wdat_nxt;
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] load_fmt;

  always_comb begin
    access = MemWrite | MemRead;
    case (Size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = Addr[0];
      2'b10:   misaligned = |Addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  always_comb begin
    be_nxt   = 4'b1111;
    wdat_nxt = WData;
    case (Size)
      2'b00: begin
        be_nxt   = 4'b0001 << Addr[1:0];
        wdat_nxt = {4{WData[7:0]}};
      end
      2'b01: begin
        be_nxt   = 4'b0011 << Addr[1:0];
        wdat_nxt = {2{WData[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (lane_q)
      2'd0:    byte_val = BusRData[7:0];
      2'd1:    byte_val = BusRData[15:8];
      2'd2:    byte_val = BusRData[23:16];
      default: byte_val = BusRData[31:24];
    endcase
    half_val = lane_q[1] ? BusRData[31:16] : BusRData[15:0];
    case (size_q)
      2'b00:   load_fmt = uns_q ? {24'd0, byte_val} : {{24{byte_val[7]}}, byte_val};
      2'b01:   load_fmt = uns_q ? {16'd0, half_val} : {{16{half_val[15]}}, half_val};
      default: load_fmt = BusRData;
    endcase
  end

  // Stall and Misalign stay combinational so they follow the current instruction even when gated.
  assign Stall    = ((state == IDLE) && access && !misaligned) || (state == REQ);
  assign Misalign = (state == IDLE) && access && misaligned;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state    <= IDLE;
      tmo_cnt  <= 16'd0;
      size_q   <= 2'b00;
      uns_q    <= 1'b0;
      lane_q   <= 2'b00;
      RData    <= 32'd0;
      BusErr   <= 1'b0;
      BusReq   <= 1'b0;
      BusWe    <= 1'b0;
      BusAddr  <= 32'd0;
      BusBe    <= 4'd0;
      BusWData <= 32'd0;
    end else if (ClockEnable) begin
      case (state)
        IDLE: begin
          BusErr <= 1'b0;
          if (access && !misaligned) begin
            state    <= REQ;
            tmo_cnt  <= 16'd0;
            BusReq   <= 1'b1;
            BusWe    <= MemWrite;
            BusAddr  <= {Addr[31:2], 2'b00};
            BusBe    <= be_nxt;
            BusWData <= wdat_nxt;
            size_q   <= Size;
            uns_q    <= Unsigned;
            lane_q   <= Addr[1:0];
          end
        end
        REQ: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (BusAck) begin
            BusReq <= 1'b0;
            RData  <= BusWe ? 32'd0 : load_fmt;
            state  <= DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            BusReq <= 1'b0;
            RData  <= 32'd0;
            BusErr <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          BusErr <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: inputs change 1 time unit after the rising edge,
// outputs are compared 2 time units after it.
module tb_mem_access_unit;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        ClockEnable = 1'b1;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [31:0] Addr = 32'd0;
  logic [31:0] WData = 32'd0;
  logic [1:0]  Size = 2'b00;
  logic        Unsigned = 1'b0;
  logic        Stall;
  logic [31:0] RData;
  logic        Misalign;
  logic        BusErr;
  logic        BusReq;
  logic        BusWe;
  logic [31:0] BusAddr;
  logic [3:0]  BusBe;
  logic [31:0] BusWData;
  logic        BusAck = 1'b0;
  logic [31:0] BusRData = 32'd0;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.TimeoutCycles(4)) dut (
    .Clock(Clock), .Reset(Reset), .ClockEnable(ClockEnable),
    .MemWrite(MemWrite), .MemRead(MemRead), .Addr(Addr), .WData(WData),
    .Size(Size), .Unsigned(Unsigned), .Stall(Stall), .RData(RData),
    .Misalign(Misalign), .BusErr(BusErr), .BusReq(BusReq), .BusWe(BusWe),
    .BusAddr(BusAddr), .BusBe(BusBe), .BusWData(BusWData),
    .BusAck(BusAck), .BusRData(BusRData)
  );

  always #5 Clock = ~Clock;

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset;
    Reset = 1'b0;
    tick();
    tick();
    #1;
    checks++; if (BusReq !== 1'b0) begin errors++; $display("FAIL reset_busreq got %h exp 0", BusReq); end
    checks++; if (BusWe !== 1'b0) begin errors++; $display("FAIL reset_buswe got %h exp 0", BusWe); end
    checks++; if (BusAddr !== 32'd0) begin errors++; $display("FAIL reset_busaddr got %h exp 0", BusAddr); end
    checks++; if (BusBe !== 4'd0) begin errors++; $display("FAIL reset_busbe got %h exp 0", BusBe); end
    checks++; if (BusWData !== 32'd0) begin errors++; $display("FAIL reset_buswdata got %h exp 0", BusWData); end
    checks++; if (RData !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h exp 0", RData); end
    checks++; if (BusErr !== 1'b0) begin errors++; $display("FAIL reset_buserr got %h exp 0", BusErr); end
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %h exp 0", Stall); end
    checks++; if (Misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %h exp 0", Misalign); end
    Reset = 1'b1;
  endtask

  task automatic test_word_store;
    tick();
    MemWrite = 1'b1; Addr = 32'h100; WData = 32'hDEADBEEF; Size = 2'b10;
    #1;
    checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL ws_stall_c0 got %h exp 1", Stall); end
    checks++; if (BusReq !== 1'b0) begin errors++; $display("FAIL ws_busreq_c0 got %h exp 0", BusReq); end
    tick();
    BusAck = 1'b1;
    #1;
    checks++; if (BusReq !== 1'b1) begin errors++; $display("FAIL ws_busreq_c1 got %h exp 1", BusReq); end
    checks++; if (BusAddr !== 32'h100) begin errors++; $display("FAIL ws_busaddr got %h exp 100", BusAddr); end
    checks++; if (BusBe !== 4'b1111) begin errors++; $display("FAIL ws_busbe got %b exp 1111", BusBe); end
    checks++; if (BusWe !== 1'b1) begin errors++; $display("FAIL ws_buswe got %h exp 1", BusWe); end
    checks++; if (BusWData !== 32'hDEADBEEF) begin errors++; $display("FAIL ws_buswdata got %h exp deadbeef", BusWData); end
    checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL ws_stall_c1 got %h exp 1", Stall); end
    tick();
    BusAck = 1'b0; MemWrite = 1'b0;
    #1;
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL ws_stall_done got %h exp 0", Stall); end
    checks++; if (BusReq !== 1'b0) begin errors++; $display("FAIL ws_busreq_done got %h exp 0", BusReq); end
    checks++; if (RData !== 32'd0) begin errors++; $display("FAIL ws_rdata got %h exp 0", RData); end
  endtask

  task automatic test_byte_load(input logic uns, input logic [31:0] exp);
    tick();
    MemRead = 1'b1; Addr = 32'h203; Size = 2'b00; Unsigned = uns;
    #1;
    tick();
    BusAck = 1'b1; BusRData = 32'h80FF1234;
    #1;
    checks++; if (BusBe !== 4'b1000) begin errors++; $display("FAIL bl_busbe got %b exp 1000", BusBe); end
    checks++; if (BusWe !== 1'b0) begin errors++; $display("FAIL bl_buswe got %h exp 0", BusWe); end
    checks++; if (BusAddr !== 32'h200) begin errors++; $display("FAIL bl_busaddr got %h exp 200", BusAddr); end
    tick();
    BusAck = 1'b0; MemRead = 1'b0;
    #1;
    checks++; if (RData !== exp) begin errors++; $display("FAIL bl_rdata uns=%0d got %h exp %h", uns, RData, exp); end
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL bl_stall_done got %h exp 0", Stall); end
  endtask

  task automatic test_half_and_misalign;
    tick();
    MemWrite = 1'b1; Addr = 32'h12; WData = 32'h0000ABCD; Size = 2'b01;
    #1;
    tick();
    BusAck = 1'b1;
    #1;
    checks++; if (BusBe !== 4'b1100) begin errors++; $display("FAIL hs_busbe got %b exp 1100", BusBe); end
    checks++; if (BusWData !== 32'hABCDABCD) begin errors++; $display("FAIL hs_buswdata got %h exp abcdabcd", BusWData); end
    checks++; if (BusAddr !== 32'h10) begin errors++; $display("FAIL hs_busaddr got %h exp 10", BusAddr); end
    tick();
    BusAck = 1'b0; MemWrite = 1'b0;
    tick();
    MemRead = 1'b1; Addr = 32'h11; Size = 2'b01;
    #1;
    checks++; if (Misalign !== 1'b1) begin errors++; $display("FAIL ma_half_pulse got %h exp 1", Misalign); end
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL ma_half_stall got %h exp 0", Stall); end
    tick();
    MemRead = 1'b0;
    #1;
    checks++; if (BusReq !== 1'b0) begin errors++; $display("FAIL ma_half_busreq got %h exp 0", BusReq); end
    checks++; if (Misalign !== 1'b0) begin errors++; $display("FAIL ma_half_clear got %h exp 0", Misalign); end
    MemWrite = 1'b1; Addr = 32'h0; Size = 2'b11;
    #1;
    checks++; if (Misalign !== 1'b1) begin errors++; $display("FAIL ma_size3_pulse got %h exp 1", Misalign); end
    tick();
    MemWrite = 1'b0;
    #1;
    checks++; if (BusReq !== 1'b0) begin errors++; $display("FAIL ma_size3_busreq got %h exp 0", BusReq); end
  endtask

  task automatic test_clock_enable;
    tick();
    MemRead = 1'b1; Addr = 32'h500; Size = 2'b10; Unsigned = 1'b0;
    #1;
    tick();
    ClockEnable = 1'b0; BusAck = 1'b1; BusRData = 32'hCAFEF00D;
    #1;
    tick();
    #1;
    checks++; if (BusReq !== 1'b1) begin errors++; $display("FAIL ce_busreq_held got %h exp 1", BusReq); end
    checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL ce_stall_held got %h exp 1", Stall); end
    ClockEnable = 1'b1;
    tick();
    BusAck = 1'b0; MemRead = 1'b0;
    #1;
    checks++; if (RData !== 32'hCAFEF00D) begin errors++; $display("FAIL ce_rdata got %h exp cafef00d", RData); end
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL ce_stall_done got %h exp 0", Stall); end
  endtask

  task automatic test_timeout;
    tick();
    MemRead = 1'b1; Addr = 32'h40; Size = 2'b10;
    #1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      #1;
      checks++; if (BusReq !== 1'b1) begin errors++; $display("FAIL to_busreq c%0d got %h exp 1", i, BusReq); end
    end
    tick();
    MemRead = 1'b0;
    #1;
    checks++; if (BusReq !== 1'b0) begin errors++; $display("FAIL to_busreq_drop got %h exp 0", BusReq); end
    checks++; if (BusErr !== 1'b1) begin errors++; $display("FAIL to_buserr got %h exp 1", BusErr); end
    checks++; if (RData !== 32'd0) begin errors++; $display("FAIL to_rdata got %h exp 0", RData); end
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL to_stall got %h exp 0", Stall); end
    tick();
    #1;
    checks++; if (BusErr !== 1'b0) begin errors++; $display("FAIL to_buserr_pulse got %h exp 0", BusErr); end
  endtask

  task automatic test_back_to_back;
    tick();
    MemRead = 1'b1; Addr = 32'h300; Size = 2'b10; Unsigned = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL bb1_stall c%0d got %h exp 1", c, Stall); end
      tick();
    end
    BusAck = 1'b1; BusRData = 32'h11112222;
    #1;
    checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL bb1_stall c3 got %h exp 1", Stall); end
    tick();
    BusAck = 1'b0;
    #1;
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL bb1_stall_done got %h exp 0", Stall); end
    checks++; if (RData !== 32'h11112222) begin errors++; $display("FAIL bb1_rdata got %h exp 11112222", RData); end
    tick();
    Addr = 32'h302; Size = 2'b01; Unsigned = 1'b1;
    #1;
    checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL bb2_stall_idle got %h exp 1", Stall); end
    checks++; if (BusReq !== 1'b0) begin errors++; $display("FAIL bb2_busreq_idle got %h exp 0", BusReq); end
    tick();
    #1;
    checks++; if (BusReq !== 1'b1) begin errors++; $display("FAIL bb2_busreq_rise got %h exp 1", BusReq); end
    checks++; if (BusBe !== 4'b1100) begin errors++; $display("FAIL bb2_busbe got %b exp 1100", BusBe); end
    checks++; if (BusAddr !== 32'h300) begin errors++; $display("FAIL bb2_busaddr got %h exp 300", BusAddr); end
    tick();
    tick();
    BusAck = 1'b1; BusRData = 32'h9ABC0000;
    #1;
    checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL bb2_stall_ack got %h exp 1", Stall); end
    tick();
    BusAck = 1'b0; MemRead = 1'b0;
    #1;
    checks++; if (RData !== 32'h00009ABC) begin errors++; $display("FAIL bb2_rdata got %h exp 00009abc", RData); end
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL bb2_stall_done got %h exp 0", Stall); end
  endtask

  task automatic test_reset_mid_access;
    tick();
    MemRead = 1'b1; Addr = 32'h600; Size = 2'b10; Unsigned = 1'b0;
    #1;
    tick();
    #1;
    checks++; if (BusReq !== 1'b1) begin errors++; $display("FAIL rm_busreq_req got %h exp 1", BusReq); end
    Reset = 1'b0; MemRead = 1'b0;
    tick();
    #1;
    checks++; if (BusReq !== 1'b0) begin errors++; $display("FAIL rm_busreq_reset got %h exp 0", BusReq); end
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL rm_stall_reset got %h exp 0", Stall); end
    checks++; if (RData !== 32'd0) begin errors++; $display("FAIL rm_rdata_reset got %h exp 0", RData); end
    checks++; if (BusAddr !== 32'd0) begin errors++; $display("FAIL rm_busaddr_reset got %h exp 0", BusAddr); end
    Reset = 1'b1;
    tick();
    BusAck = 1'b1; BusRData = 32'h55AA55AA;
    #1;
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL rm_stall_lateack got %h exp 0", Stall); end
    tick();
    BusAck = 1'b0;
    #1;
    checks++; if (RData !== 32'd0) begin errors++; $display("FAIL rm_rdata_lateack got %h exp 0", RData); end
    checks++; if (BusReq !== 1'b0) begin errors++; $display("FAIL rm_busreq_lateack got %h exp 0", BusReq); end
    checks++; if (BusErr !== 1'b0) begin errors++; $display("FAIL rm_buserr_lateack got %h exp 0", BusErr); end
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_byte_load(1'b0, 32'hFFFFFF80);
    test_byte_load(1'b1, 32'h00000080);
    test_half_and_misalign();
    test_clock_enable();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
